lane_test_seq: RTL and testbench

- Sequences a built-in self-test of an analog lane bank.
- Forces the lanes into bypass (ana_byp), toggles the lane inputs, and checks that each enabled lane's output changes within a programmable window.
- Sits between the test/CSR block (start, config, result) and the lane bank's test-mode ports, all on the functional clock.

---
 rtl/lane_test_pkg.sv | 15 +
 rtl/lane_test_seq_if.sv | 36 +++
 rtl/lane_change_detect.sv | 34 +++
 rtl/lane_test_seq.sv | 195 +++++++++++++++++++
 tb/tb_lane_test_seq.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lane_test_pkg.sv
// Shared types for the lane bank self-test sequencer.
// Optional build macro: LANE_TEST_WALK_EN (walk one lane per toggle).
package lane_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DRIVE,
    ST_WAIT,
    ST_DONE
  } lt_state_e;

  localparam int SETTLE_DEF = 2;

endpackage

// File: rtl/lane_test_seq_if.sv
// CSR-side and lane-bank-side signals of the lane self-test sequencer.
// slave = sequencer, master = CSR block / lane bank model.
interface lane_test_seq_if #(
  parameter int NUM_LANES = 8,
  parameter int WAIT_W    = 4,
  parameter int ITER_W    = 8
);

  logic                 start_i;
  logic                 abort_i;
  logic [ITER_W-1:0]    cfg_iters_i;
  logic [WAIT_W-1:0]    cfg_wait_i;
  logic [NUM_LANES-1:0] lane_en_i;
  logic [NUM_LANES-1:0] lane_outputs_i;
  logic                 ana_byp_o;
  logic [NUM_LANES-1:0] lane_inputs_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 pass_o;
  logic [NUM_LANES-1:0] fail_lanes_o;

  modport master (
    output start_i, abort_i, cfg_iters_i, cfg_wait_i,
    output lane_en_i, lane_outputs_i,
    input  ana_byp_o, lane_inputs_o, busy_o,
    input  done_o, pass_o, fail_lanes_o
  );

  modport slave (
    input  start_i, abort_i, cfg_iters_i, cfg_wait_i,
    input  lane_en_i, lane_outputs_i,
    output ana_byp_o, lane_inputs_o, busy_o,
    output done_o, pass_o, fail_lanes_o
  );

endinterface

// File: rtl/lane_change_detect.sv
// Snapshot of lane outputs plus sticky mask of lanes that moved since.
// seen includes the current cycle's difference so a check can end early.
module lane_change_detect #(
  parameter int NUM_LANES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 capture,
  input  logic [NUM_LANES-1:0] en,
  input  logic [NUM_LANES-1:0] lane_outputs,
  output logic [NUM_LANES-1:0] seen,
  output logic                 all_seen
);

  logic [NUM_LANES-1:0] snap_q;
  logic [NUM_LANES-1:0] seen_q;

  assign seen     = seen_q | ((lane_outputs ^ snap_q) & en);
  assign all_seen = (seen == en);

  // Capture reference and clear history, otherwise accumulate changes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q <= '0;
      seen_q <= '0;
    end else if (capture) begin
      snap_q <= lane_outputs;
      seen_q <= '0;
    end else begin
      seen_q <= seen;
    end
  end

endmodule

// File: rtl/lane_test_seq.sv
// Lane bank self-test: bypass, toggle lane inputs, check responses.
// Optional build macro: LANE_TEST_WALK_EN (one enabled lane per toggle).
module lane_test_seq
  import lane_test_pkg::*;
#(
  parameter int NUM_LANES = 8,
  parameter int WAIT_W    = 4,
  parameter int ITER_W    = 8,
  parameter int SETTLE    = SETTLE_DEF
) (
  input logic            clk,
  input logic            rst_n,
  lane_test_seq_if.slave bus
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  lt_state_e            st_q;
  lt_state_e            st_d;
  logic [SW-1:0]        set_q;
  logic [ITER_W-1:0]    rem_q;
  logic [WAIT_W-1:0]    win_q;
  logic [WAIT_W-1:0]    cnt_q;
  logic [NUM_LANES-1:0] en_q;
  logic [NUM_LANES-1:0] lin_q;
  logic [NUM_LANES-1:0] fail_q;
  logic [NUM_LANES-1:0] eff;
  logic [NUM_LANES-1:0] eff_nxt;
  logic [NUM_LANES-1:0] seen;
  logic                 all_seen;
  logic                 pass_q;
  logic                 abt_q;
  logic                 accept;
  logic                 drive;
  logic                 expire;
  logic                 iter_end;
  logic                 abort;
  logic                 enter_done;

  lane_change_detect #(
    .NUM_LANES(NUM_LANES)
  ) u_det (
    .clk         (clk),
    .rst_n       (rst_n),
    .capture     (drive),
    .en          (eff),
    .lane_outputs(bus.lane_outputs_i),
    .seen        (seen),
    .all_seen    (all_seen)
  );

`ifdef LANE_TEST_WALK_EN
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [LW-1:0]        ptr_q;
  logic [LW-1:0]        pick_idx;
  logic [NUM_LANES-1:0] pick;
  logic [NUM_LANES-1:0] eff_q;

  // Next enabled lane after the last one walked, wrapping
  always_comb begin
    int j;
    j        = 0;
    pick     = '0;
    pick_idx = ptr_q;
    for (int k = NUM_LANES; k >= 1; k--) begin
      j = (int'(ptr_q) + k) % NUM_LANES;
      if (en_q[j]) pick_idx = LW'(j);
    end
    if (|en_q) pick[pick_idx] = 1'b1;
  end

  // Walk pointer and the single lane under check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= LW'(NUM_LANES - 1);
      eff_q <= '0;
    end else if (accept) begin
      ptr_q <= LW'(NUM_LANES - 1);
      eff_q <= '0;
    end else if (drive) begin
      ptr_q <= pick_idx;
      eff_q <= pick;
    end
  end

  assign eff_nxt = pick;
  assign eff     = eff_q;
`else
  assign eff_nxt = en_q;
  assign eff     = en_q;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st_q <= ST_IDLE;
    else        st_q <= st_d;
  end

  // Next state and per-cycle control strobes
  always_comb begin
    st_d     = st_q;
    accept   = 1'b0;
    drive    = 1'b0;
    expire   = 1'b0;
    iter_end = 1'b0;
    abort    = 1'b0;
    unique case (st_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          accept = 1'b1;
          st_d   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (set_q == SW'(SETTLE - 1)) st_d = ST_DRIVE;
      end
      ST_DRIVE: begin
        drive = 1'b1;
        st_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (all_seen) begin
          iter_end = 1'b1;
        end else if (cnt_q == win_q) begin
          expire   = 1'b1;
          iter_end = 1'b1;
        end
        if (iter_end) begin
          st_d = (rem_q == ITER_W'(1)) ? ST_DONE : ST_DRIVE;
        end
      end
      ST_DONE: st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
    if (bus.abort_i &&
        (st_q inside {ST_SETTLE, ST_DRIVE, ST_WAIT})) begin
      abort    = 1'b1;
      drive    = 1'b0;
      expire   = 1'b0;
      iter_end = 1'b0;
      st_d     = ST_DONE;
    end
  end

  assign enter_done = (st_d == ST_DONE) && (st_q != ST_DONE);

  // Config capture, counters, stimulus and result bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_q  <= '0;
      rem_q  <= '0;
      win_q  <= '0;
      cnt_q  <= '0;
      en_q   <= '0;
      lin_q  <= '0;
      fail_q <= '0;
      pass_q <= 1'b0;
      abt_q  <= 1'b0;
    end else begin
      if (accept) begin
        en_q   <= bus.lane_en_i;
        rem_q  <= (bus.cfg_iters_i == '0) ? ITER_W'(1)
                                          : bus.cfg_iters_i;
        win_q  <= (bus.cfg_wait_i == '0) ? '0
                  : bus.cfg_wait_i - WAIT_W'(1);
        fail_q <= '0;
        pass_q <= 1'b0;
        abt_q  <= 1'b0;
        set_q  <= '0;
      end
      if (st_q == ST_SETTLE) set_q <= set_q + SW'(1);
      if (drive) begin
        lin_q <= lin_q ^ eff_nxt;
        cnt_q <= '0;
      end else if (st_q == ST_WAIT && !iter_end) begin
        cnt_q <= cnt_q + WAIT_W'(1);
      end
      if (expire)   fail_q <= fail_q | (eff & ~seen);
      if (iter_end) rem_q  <= rem_q - ITER_W'(1);
      if (abort)    abt_q  <= 1'b1;
      if (enter_done) lin_q <= '0;
      if (st_q == ST_DONE) pass_q <= ~|fail_q & ~abt_q;
    end
  end

  assign bus.ana_byp_o     = st_q inside {ST_SETTLE, ST_DRIVE, ST_WAIT};
  assign bus.lane_inputs_o = lin_q;
  assign bus.busy_o        = (st_q != ST_IDLE);
  assign bus.done_o        = (st_q == ST_DONE);
  assign bus.pass_o        = (st_q == ST_DONE) ? (~|fail_q & ~abt_q)
                                               : pass_q;
  assign bus.fail_lanes_o  = fail_q;

endmodule

// File: tb/tb_lane_test_seq.sv
// Directed bench for lane_test_seq with a one-cycle echoing lane bank.
// Walk-order expectations follow LANE_TEST_WALK_EN.
module tb_lane_test_seq;

  logic clk;
  logic rst_n;
  logic [7:0] stuck;
  logic [7:0] echo_q;

  int n_cmp;
  int n_bad;
  int byp_low;
  int nchg;
  int cyc;
  int dn;
  logic [7:0] in_or;
  logic [31:0] pk;

  lane_test_seq_if #(
    .NUM_LANES(8),
    .WAIT_W   (4),
    .ITER_W   (8)
  ) bus ();

  lane_test_seq dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane bank model: outputs follow inputs one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) echo_q <= '0;
    else        echo_q <= bus.lane_inputs_o;
  end
  assign bus.lane_outputs_i = echo_q & ~stuck;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [7:0] en,
                     input logic [7:0] it,
                     input logic [3:0] wt,
                     input int hold);
    logic [7:0] prev;
    bus.lane_en_i   = en;
    bus.cfg_iters_i = it;
    bus.cfg_wait_i  = wt;
    bus.start_i     = 1'b1;
    step();
    cyc     = 0;
    byp_low = 0;
    nchg    = 0;
    in_or   = '0;
    pk      = '0;
    prev    = '0;
    while (!bus.done_o && cyc < 200) begin
      if (cyc == hold) begin
        bus.start_i     = 1'b0;
        bus.abort_i     = 1'b0;
        bus.lane_en_i   = ~en;
        bus.cfg_iters_i = 8'd1;
        bus.cfg_wait_i  = 4'd1;
      end
      if (!bus.ana_byp_o) byp_low++;
      in_or = in_or | bus.lane_inputs_o;
      if (bus.lane_inputs_o != prev) begin
        nchg++;
        pk   = {pk[23:0], bus.lane_inputs_o};
        prev = bus.lane_inputs_o;
      end
      step();
      cyc++;
    end
    bus.start_i = 1'b0;
    chk("done_seen", 32'(bus.done_o), 32'd1);
    chk("done_byp", 32'(bus.ana_byp_o), 32'd0);
    chk("done_lin", 32'(bus.lane_inputs_o), 32'd0);
    chk("done_busy", 32'(bus.busy_o), 32'd1);
  endtask

  task automatic after_done(input logic exp_pass);
    step();
    chk("idle_done", 32'(bus.done_o), 32'd0);
    chk("idle_busy", 32'(bus.busy_o), 32'd0);
    chk("idle_pass", 32'(bus.pass_o), 32'(exp_pass));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    stuck = '0;
    bus.start_i     = 1'b0;
    bus.abort_i     = 1'b0;
    bus.cfg_iters_i = '0;
    bus.cfg_wait_i  = '0;
    bus.lane_en_i   = '0;
    repeat (3) step();
    chk("rst_byp", 32'(bus.ana_byp_o), 32'd0);
    chk("rst_lin", 32'(bus.lane_inputs_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_done", 32'(bus.done_o), 32'd0);
    chk("rst_pass", 32'(bus.pass_o), 32'd0);
    chk("rst_fail", 32'(bus.fail_lanes_o), 32'd0);
    rst_n = 1'b1;
    step();

    // all lanes respond
    run(8'hFF, 8'd3, 4'd4, 0);
    chk("clean_cyc", 32'(cyc), 32'd11);
    chk("clean_byp", 32'(byp_low), 32'd0);
    chk("clean_seq", pk, 32'h00FF00FF);
    chk("clean_nchg", 32'(nchg), 32'd3);
    chk("clean_pass", 32'(bus.pass_o), 32'd1);
    chk("clean_fail", 32'(bus.fail_lanes_o), 32'd0);
    after_done(1'b1);

    // lane 5 stuck
    stuck = 8'h20;
    run(8'hFF, 8'd2, 4'd4, 0);
    chk("stuck_cyc", 32'(cyc), 32'd12);
    chk("stuck_fail", 32'(bus.fail_lanes_o), 32'h20);
    chk("stuck_pass", 32'(bus.pass_o), 32'd0);
    after_done(1'b0);

    // lane 6 stuck but not enabled
    stuck = 8'h40;
    run(8'h0F, 8'd2, 4'd4, 0);
    chk("part_cyc", 32'(cyc), 32'd8);
    chk("part_inor", 32'(in_or), 32'h0F);
    chk("part_pass", 32'(bus.pass_o), 32'd1);
    chk("part_fail", 32'(bus.fail_lanes_o), 32'd0);
    after_done(1'b1);

    // zero config, no response
    stuck = 8'hFF;
    run(8'h3C, 8'd0, 4'd0, 0);
    chk("zero_cyc", 32'(cyc), 32'd4);
    chk("zero_seq", pk, 32'h0000003C);
    chk("zero_fail", 32'(bus.fail_lanes_o), 32'h3C);
    chk("zero_pass", 32'(bus.pass_o), 32'd0);
    after_done(1'b0);

    // no lanes enabled
    stuck = 8'h00;
    run(8'h00, 8'd1, 4'd4, 0);
    chk("none_cyc", 32'(cyc), 32'd4);
    chk("none_pass", 32'(bus.pass_o), 32'd1);
    after_done(1'b1);

    // abort one cycle into the second window
    stuck = 8'h20;
    bus.lane_en_i   = 8'hFF;
    bus.cfg_iters_i = 8'd3;
    bus.cfg_wait_i  = 4'd2;
    bus.start_i     = 1'b1;
    step();
    bus.start_i = 1'b0;
    repeat (7) step();
    chk("abt_pre_byp", 32'(bus.ana_byp_o), 32'd1);
    bus.abort_i = 1'b1;
    step();
    bus.abort_i = 1'b0;
    chk("abt_done", 32'(bus.done_o), 32'd1);
    chk("abt_pass", 32'(bus.pass_o), 32'd0);
    chk("abt_fail", 32'(bus.fail_lanes_o), 32'h20);
    chk("abt_byp", 32'(bus.ana_byp_o), 32'd0);
    chk("abt_lin", 32'(bus.lane_inputs_o), 32'd0);
    after_done(1'b0);

    // start and abort together: start wins, clean rerun
    stuck = 8'h00;
    bus.abort_i = 1'b1;
    run(8'hFF, 8'd3, 4'd4, 0);
    chk("rerun_cyc", 32'(cyc), 32'd11);
    chk("rerun_fail", 32'(bus.fail_lanes_o), 32'd0);
    chk("rerun_pass", 32'(bus.pass_o), 32'd1);
    after_done(1'b1);

    // start held high while busy
    run(8'hFF, 8'd3, 4'd4, 6);
    chk("hold_cyc", 32'(cyc), 32'd11);
    chk("hold_pass", 32'(bus.pass_o), 32'd1);
    after_done(1'b1);

    // toggle order
    run(8'h05, 8'd4, 4'd4, 0);
    chk("order_cyc", 32'(cyc), 32'd14);
    chk("order_nchg", 32'(nchg), 32'd4);
`ifdef LANE_TEST_WALK_EN
    chk("order_seq", pk, 32'h01050400);
`else
    chk("order_seq", pk, 32'h05000500);
`endif
    chk("order_pass", 32'(bus.pass_o), 32'd1);
    after_done(1'b1);

    // reset mid-window
    bus.lane_en_i   = 8'hFF;
    bus.cfg_iters_i = 8'd3;
    bus.cfg_wait_i  = 4'd4;
    bus.start_i     = 1'b1;
    step();
    repeat (4) step();
    chk("mid_lin", 32'(bus.lane_inputs_o), 32'hFF);
    chk("mid_byp", 32'(bus.ana_byp_o), 32'd1);
    #2;
    rst_n       = 1'b0;
    bus.start_i = 1'b0;
    #1;
    chk("arst_byp", 32'(bus.ana_byp_o), 32'd0);
    chk("arst_lin", 32'(bus.lane_inputs_o), 32'd0);
    chk("arst_busy", 32'(bus.busy_o), 32'd0);
    chk("arst_done", 32'(bus.done_o), 32'd0);
    dn = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) rst_n = 1'b1;
      step();
      if (bus.done_o) dn++;
    end
    chk("arst_nodone", 32'(dn), 32'd0);
    chk("arst_idle", 32'(bus.busy_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
